// File: rtl/multi_channel_adc_model_pkg.sv
// Shared types and constants for the multi-channel ADC model and its helpers.
// Holds the FSM state encoding, LFSR polynomial and status word bit positions.
package multi_channel_adc_pkg;

    typedef enum logic [1:0] {
        ADC_IDLE    = 2'd0,
        ADC_SAMPLE  = 2'd1,
        ADC_CONVERT = 2'd2,
        ADC_DONE    = 2'd3
    } adc_state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_VALID_BIT = 1;
    localparam int STATUS_OVR_BIT   = 2;
    localparam int STATUS_SCAN_BIT  = 3;
    localparam int STATUS_AVG_BIT   = 4;
    localparam int STATUS_CH_LSB    = 8;
    localparam int STATUS_RES_LSB   = 16;

    localparam int AVG_SAMPLES = 4;

    // Galois form, shifting right: the mask is folded in whenever bit 0 falls out.
    function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/multi_channel_adc_model_if.sv
// Result handshake between the ADC model (master) and its consumer (slave).
interface multi_channel_adc_model_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_W       = 2
);
    logic                  meas_valid;
    logic                  meas_ready;
    logic [DATA_WIDTH-1:0] measurement;
    logic [CH_W-1:0]       meas_channel;

    modport master (
        output meas_valid,
        output measurement,
        output meas_channel,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  measurement,
        input  meas_channel,
        output meas_ready
    );
endinterface

// File: rtl/multi_channel_adc_model_lfsr.sv
// adc_lfsr32: free-running 32-bit Galois LFSR shared by the sensor models.
module adc_lfsr32
    import multi_channel_adc_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else if (en) begin
            state <= lfsr32_next(state);
        end
    end

endmodule

// File: rtl/multi_channel_adc_model.sv
// Multi-channel SAR ADC behavioural model: trigger/scan FSM, fixed conversion latency, LFSR samples.
// Define ADC_MODEL_AVERAGE_EN to average AVG_SAMPLES captures per conversion with round-half-up.
module multi_channel_adc_model
    import multi_channel_adc_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          RESOLUTION   = 12,
    parameter int          NUM_CHANNELS = 4,
    parameter int          CONV_CYCLES  = 16,
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
    localparam int         CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trigger,
    input  logic                    scan_en,
    input  logic [CH_W-1:0]         channel_sel,
    input  logic [NUM_CHANNELS-1:0] analog_in,
    input  logic                    status_clr,
    multi_channel_adc_model_if.master meas,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   status
);

    localparam logic [1:0] S_IDLE    = ADC_IDLE;
    localparam logic [1:0] S_SAMPLE  = ADC_SAMPLE;
    localparam logic [1:0] S_CONVERT = ADC_CONVERT;
    localparam logic [1:0] S_DONE    = ADC_DONE;

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

`ifdef ADC_MODEL_AVERAGE_EN
    localparam logic AVG_EN = 1'b1;
    localparam int   AVG_W  = $clog2(AVG_SAMPLES);
    localparam int   ACC_W  = RESOLUTION + AVG_W;
`else
    localparam logic AVG_EN = 1'b0;
`endif

    logic [1:0]            state;
    logic [31:0]           lfsr;
    logic [CH_W-1:0]       cur_ch;
    logic [CH_W-1:0]       scan_ch;
    logic [CNT_W-1:0]      conv_cnt;
    logic [RESOLUTION-1:0] result;
    logic                  meas_valid_r;
    logic                  overrun;
    logic                  analog_bit;
    logic [RESOLUTION-1:0] capture;
    logic                  lfsr_unused;
`ifdef ADC_MODEL_AVERAGE_EN
    logic [AVG_W-1:0]      avg_idx;
    logic [ACC_W-1:0]      acc;
`endif

    function automatic logic [CH_W-1:0] wrap_ch(input logic [CH_W-1:0] sel);
        return CH_W'(32'(sel) % 32'(NUM_CHANNELS));
    endfunction

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch + 1'b1;
    endfunction

`ifdef ADC_MODEL_AVERAGE_EN
    function automatic logic [RESOLUTION-1:0] round_avg(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] biased;
        // Headroom: AVG_SAMPLES*(2^RES-1) + AVG_SAMPLES/2 still fits in ACC_W bits.
        biased = sum + ACC_W'(AVG_SAMPLES / 2);
        return biased[ACC_W-1:AVG_W];
    endfunction
`endif

    adc_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .state (lfsr)
    );

    assign capture     = {analog_bit, lfsr[RESOLUTION-2:0]};
    assign lfsr_unused = ^lfsr[31:RESOLUTION-1];

    // Control: FSM, counters, channel tracking, sticky overrun and the output result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cur_ch       <= '0;
            scan_ch      <= '0;
            conv_cnt     <= '0;
            result       <= '0;
            meas_valid_r <= 1'b0;
            overrun      <= 1'b0;
`ifdef ADC_MODEL_AVERAGE_EN
            avg_idx      <= '0;
`endif
        end else begin
            if (trigger && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (status_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        cur_ch <= scan_en ? scan_ch : wrap_ch(channel_sel);
                        state  <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    conv_cnt <= CNT_LOAD;
`ifdef ADC_MODEL_AVERAGE_EN
                    avg_idx  <= '0;
`endif
                    state    <= S_CONVERT;
                end
                S_CONVERT: begin
                    if (conv_cnt == '0) begin
`ifdef ADC_MODEL_AVERAGE_EN
                        if (avg_idx == AVG_W'(AVG_SAMPLES - 1)) begin
                            result       <= round_avg(acc + ACC_W'(capture));
                            meas_valid_r <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            avg_idx  <= avg_idx + 1'b1;
                            conv_cnt <= CNT_LOAD;
                        end
`else
                        result       <= capture;
                        meas_valid_r <= 1'b1;
                        state        <= S_DONE;
`endif
                    end else begin
                        conv_cnt <= conv_cnt - 1'b1;
                    end
                end
                default: begin
                    if (meas_valid_r && meas.meas_ready) begin
                        meas_valid_r <= 1'b0;
                        if (scan_en) begin
                            scan_ch <= next_ch(scan_ch);
                            cur_ch  <= next_ch(scan_ch);
                            state   <= S_SAMPLE;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Datapath: comparator latch and accumulator carry no reset; the FSM qualifies them.
    always_ff @(posedge clk) begin
        if (state == S_SAMPLE) begin
            analog_bit <= analog_in[cur_ch];
        end
`ifdef ADC_MODEL_AVERAGE_EN
        if (state == S_SAMPLE) begin
            acc <= '0;
        end else if ((state == S_CONVERT) && (conv_cnt == '0)) begin
            acc <= acc + ACC_W'(capture);
        end
`endif
    end

    assign busy              = (state == S_SAMPLE) || (state == S_CONVERT);
    assign meas.meas_valid   = meas_valid_r;
    assign meas.measurement  = {{(DATA_WIDTH - RESOLUTION){1'b0}}, result};
    assign meas.meas_channel = cur_ch;

    always_comb begin
        status                                      = '0;
        status[STATUS_BUSY_BIT]                     = busy;
        status[STATUS_VALID_BIT]                    = meas_valid_r;
        status[STATUS_OVR_BIT]                      = overrun;
        status[STATUS_SCAN_BIT]                     = scan_en;
        status[STATUS_AVG_BIT]                      = AVG_EN;
        status[STATUS_CH_LSB +: 8]                  = 8'(cur_ch);
        status[DATA_WIDTH-1:STATUS_RES_LSB]         = (DATA_WIDTH - STATUS_RES_LSB)'(RESOLUTION);
    end

endmodule

// File: tb/tb_multi_channel_adc_model.sv
// Directed bench for multi_channel_adc_model: latency, hold, overrun, scan order, reset abort.
module tb_multi_channel_adc_model;

    localparam int          DATA_WIDTH   = 32;
    localparam int          RESOLUTION   = 12;
    localparam int          NUM_CHANNELS = 4;
    localparam int          CONV_CYCLES  = 16;
    localparam int          CH_W         = 2;
    localparam logic [31:0] SEED         = 32'h0000_0001;
    localparam logic [31:0] MASK         = 32'h8020_0003;
`ifdef ADC_MODEL_AVERAGE_EN
    localparam int   NCAP    = 4;
    localparam logic AVG_BIT = 1'b1;
`else
    localparam int   NCAP    = 1;
    localparam logic AVG_BIT = 1'b0;
`endif
    localparam int LAT = NCAP * CONV_CYCLES + 2;

    logic                    clk;
    logic                    reset;
    logic                    trigger;
    logic                    scan_en;
    logic [CH_W-1:0]         channel_sel;
    logic [NUM_CHANNELS-1:0] analog_in;
    logic                    status_clr;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   status;
    int                      cyc;
    int                      n_err;
    int                      n_chk;

    multi_channel_adc_model_if #(.DATA_WIDTH(DATA_WIDTH), .CH_W(CH_W)) mif ();

    multi_channel_adc_model #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESOLUTION   (RESOLUTION),
        .NUM_CHANNELS (NUM_CHANNELS),
        .CONV_CYCLES  (CONV_CYCLES),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .scan_en     (scan_en),
        .channel_sel (channel_sel),
        .analog_in   (analog_in),
        .status_clr  (status_clr),
        .meas        (mif),
        .busy        (busy),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; equals the number of LFSR steps taken before the next edge.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [31:0] lfsr_at(input int n);
        logic [31:0] s = SEED;
        for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ MASK) : (s >> 1);
        return s;
    endfunction

    function automatic logic [31:0] exp_res(input logic a, input int c0);
        int          sum = 0;
        logic [31:0] s;
        for (int k = 0; k < NCAP; k++) begin
            s   = lfsr_at(c0 + k * CONV_CYCLES);
            sum = sum + int'({a, s[10:0]});
        end
        if (NCAP == 1) return 32'(sum);
        return 32'((sum + 2) >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_trigger(input logic [CH_W-1:0] ch, output int tc);
        @(negedge clk);
        channel_sel = ch;
        trigger     = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        tc      = cyc - 1;
    endtask

    // Returns the index of the first edge (counted from the call point) that sees meas_valid high.
    task automatic wait_valid(output int lat);
        bit got = 0;
        lat = 0;
        while (!got && lat < LAT + 10) begin
            @(negedge clk);
            lat++;
            if (mif.meas_valid) got = 1;
        end
        if (!got) lat = -1;
    endtask

    task automatic accept();
        @(negedge clk);
        mif.meas_ready = 1'b1;
        @(posedge clk);
        #1;
        mif.meas_ready = 1'b0;
    endtask

    task automatic clear_ovr();
        @(negedge clk);
        status_clr = 1'b1;
        @(posedge clk);
        #1;
        status_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          t;
        int          lat;
        int          c;
        bit          seen;
        logic [31:0] exp;

        n_err = 0;
        n_chk = 0;
        reset = 1'b1;
        trigger = 1'b0;
        scan_en = 1'b0;
        channel_sel = '0;
        analog_in = '0;
        status_clr = 1'b0;
        mif.meas_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", mif.meas_valid, 0);
        check("rst_meas", mif.measurement, 0);
        check("rst_chan", mif.meas_channel, 0);
        check("rst_busy", busy, 0);
        check("rst_stat_lo", status[15:0], {11'd0, AVG_BIT, 4'd0});
        check("rst_stat_res", status[31:16], RESOLUTION);
        @(negedge clk);
        reset = 1'b0;

        // Single conversion on channel 2, then hold and release.
        analog_in = 4'b0100;
        do_trigger(2'd2, t);
        wait_valid(lat);
        check("latency", lat, LAT);
        exp = exp_res(1'b1, t + CONV_CYCLES + 1);
        check("meas_a", mif.measurement, exp);
        check("msb_a", mif.measurement[11], 1);
        check("chan_a", mif.meas_channel, 2);
        check("stat_a", status[4:0], {AVG_BIT, 4'b0010});
        check("stat_ch_a", status[15:8], 2);
        check("stat_res_a", status[31:16], RESOLUTION);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", mif.meas_valid, 1);
            check("hold_meas", mif.measurement, exp);
        end
        mif.meas_ready = 1'b1;
        @(posedge clk);
        #1;
        mif.meas_ready = 1'b0;
        check("drop_valid", mif.meas_valid, 0);
        check("idle_busy", busy, 0);

        // Overrun: trigger during CONVERT and during DONE, then clear.
        analog_in = 4'b0000;
        do_trigger(2'd1, t);
        repeat (5) @(posedge clk);
        @(negedge clk);
        channel_sel = 2'd3;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        wait_valid(lat);
        check("ovr_valid", mif.meas_valid, 1);
        check("ovr_meas", mif.measurement, exp_res(1'b0, t + CONV_CYCLES + 1));
        check("ovr_chan", mif.meas_channel, 1);
        check("ovr_set", status[2], 1);
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        check("done_trig_valid", mif.meas_valid, 1);
        check("done_trig_chan", mif.meas_channel, 1);
        check("done_trig_busy", busy, 0);
        accept();
        check("ovr_sticky", status[2], 1);
        clear_ovr();
        check("ovr_clr", status[2], 0);

        do_trigger(2'd0, t);
        repeat (3) @(posedge clk);
        @(negedge clk);
        trigger = 1'b1;
        status_clr = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        status_clr = 1'b0;
        check("ovr_set_wins", status[2], 1);
        wait_valid(lat);
        check("sw_chan", mif.meas_channel, 0);
        accept();
        clear_ovr();
        check("ovr_clr2", status[2], 0);

        // Scan mode with the consumer always ready.
        analog_in = 4'b1010;
        scan_en = 1'b1;
        mif.meas_ready = 1'b1;
        do_trigger(2'd3, t);
        for (int r = 0; r < 5; r++) begin
            wait_valid(lat);
            check("scan_lat", lat, LAT);
            check("scan_chan", mif.meas_channel, r % 4);
            c = cyc - 1 - (NCAP - 1) * CONV_CYCLES;
            check("scan_meas", mif.measurement, exp_res(analog_in[r % 4], c));
        end
        check("scan_stat", status[3], 1);
        @(posedge clk);
        #1;
        scan_en = 1'b0;
        wait_valid(lat);
        check("stop_lat", lat, LAT);
        check("stop_chan", mif.meas_channel, 1);
        c = cyc - 1 - (NCAP - 1) * CONV_CYCLES;
        check("stop_meas", mif.measurement, exp_res(1'b1, c));
        @(posedge clk);
        #1;
        check("stop_drop", mif.meas_valid, 0);
        seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (mif.meas_valid || busy) seen = 1;
        end
        check("stop_idle", seen, 0);
        mif.meas_ready = 1'b0;

        // Reset in the middle of a conversion.
        analog_in = 4'b0100;
        do_trigger(2'd2, t);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", mif.meas_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_meas", mif.measurement, 0);
        check("mid_rst_chan", mif.meas_channel, 0);
        check("mid_rst_stat", status[15:0], {11'd0, AVG_BIT, 4'd0});
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (mif.meas_valid || busy) seen = 1;
        end
        check("no_partial", seen, 0);

        // Recovery after reset: LFSR restarted from the seed.
        analog_in = 4'b0010;
        do_trigger(2'd1, t);
        wait_valid(lat);
        check("rec_lat", lat, LAT);
        check("rec_meas", mif.measurement, exp_res(1'b1, t + CONV_CYCLES + 1));
        check("rec_chan", mif.meas_channel, 1);
        accept();
        check("rec_drop", mif.meas_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
